// File: rtl/ifetch_prefetch_queue.sv
// Instruction prefetch queue between the core fetch port and the instruction bus.
// Sequential words ahead of the fetch PC are held in a PC-tagged FIFO. A fetch
// that matches the head is answered combinationally. A fetch that does not match
// discards the queue and restarts prefetch at the new PC. If the queue is empty
// and the word for the fetch PC is already being fetched, the request waits.
module ifetch_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req_valid,
  input  logic [AW-1:0] c_req_addr,
  output logic          c_addr_ok,
  output logic          c_data_ok,
  output logic [31:0]   c_data,
  input  logic          flush,
  output logic          b_req_valid,
  output logic [AW-1:0] b_req_addr,
  input  logic          b_addr_ok,
  input  logic          b_data_ok,
  input  logic [31:0]   b_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [AW-1:0]   tag_r  [DEPTH];
  logic [31:0]     word_r [DEPTH];
  logic [PW-1:0]   head_r, tail_r;
  logic [CW-1:0]   count_r, count_s;
  logic [AW-1:0]   pf_addr_r;
  logic            pf_en_r;

  logic            head_match_s, pop_s, pending_s, redirect_s, clear_s, push_s, room_s;

  // Classify this cycle's fetch: hit, waiting on the word in flight, or redirect
  always_comb begin
    head_match_s = 1'b0;
    pending_s    = 1'b0;
    if (c_req_valid && (count_r != '0)) begin
      head_match_s = (tag_r[head_r] == c_req_addr);
    end else begin
      head_match_s = 1'b0;
    end
    if (c_req_valid && (count_r == '0) && pf_en_r && (state_r != IDLE)) begin
      pending_s = (c_req_addr == pf_addr_r);
    end else begin
      pending_s = 1'b0;
    end
    pop_s      = head_match_s && !flush;
    redirect_s = c_req_valid && !flush && !head_match_s && !pending_s;
    clear_s    = flush || redirect_s;
    push_s     = (state_r == WAIT) && b_data_ok && !clear_s;
  end

  // Occupancy after this cycle's push/pop, and whether room remains
  always_comb begin
    count_s = count_r;
    if (push_s && !pop_s) begin
      count_s = count_r + CW'(1);
    end else if (pop_s && !push_s) begin
      count_s = count_r - CW'(1);
    end else begin
      count_s = count_r;
    end
    room_s = (count_s < CW'(DEPTH));
  end

  // Core and bus outputs; everything is zero unless actively valid
  always_comb begin
    c_addr_ok   = pop_s;
    c_data_ok   = pop_s;
    c_data      = 32'd0;
    b_req_valid = (state_r == REQ);
    b_req_addr  = '0;
    if (pop_s) begin
      c_data = word_r[head_r];
    end else begin
      c_data = 32'd0;
    end
    if (state_r == REQ) begin
      b_req_addr = pf_addr_r;
    end else begin
      b_req_addr = '0;
    end
  end

  // Bus FSM next state; flush first, then redirect, then normal prefetch
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (flush) begin
          state_s = IDLE;
        end else if (redirect_s) begin
          state_s = REQ;
        end else if (pf_en_r && (count_r < CW'(DEPTH))) begin
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (flush) begin
          state_s = b_addr_ok ? DROP : IDLE;
        end else if (redirect_s) begin
          state_s = b_addr_ok ? DROP : REQ;
        end else if (b_addr_ok) begin
          state_s = WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (flush) begin
          state_s = b_data_ok ? IDLE : DROP;
        end else if (redirect_s) begin
          state_s = b_data_ok ? REQ : DROP;
        end else if (b_data_ok) begin
          state_s = room_s ? REQ : IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      DROP: begin
        if (!b_data_ok) begin
          state_s = DROP;
        end else if (flush) begin
          state_s = IDLE;
        end else if (redirect_s || pf_en_r) begin
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state, prefetch enable and prefetch address registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      pf_en_r   <= 1'b0;
      pf_addr_r <= '0;
    end else begin
      state_r <= state_s;
      if (flush) begin
        pf_en_r <= 1'b0;
      end else if (c_req_valid) begin
        pf_en_r <= 1'b1;
      end else begin
        pf_en_r <= pf_en_r;
      end
      if (redirect_s) begin
        pf_addr_r <= c_req_addr;
      end else if (push_s) begin
        pf_addr_r <= pf_addr_r + AW'(4);
      end else begin
        pf_addr_r <= pf_addr_r;
      end
    end
  end

  // Queue pointers and occupancy; flush or redirect empties the queue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (clear_s) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PW'(1);
      end else begin
        tail_r <= tail_r;
      end
      if (pop_s) begin
        head_r <= head_r + PW'(1);
      end else begin
        head_r <= head_r;
      end
      count_r <= count_s;
    end
  end

  // Entry storage: tag is the word's fetch address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_r[i]  <= '0;
        word_r[i] <= 32'd0;
      end
    end else if (push_s) begin
      tag_r[tail_r]  <= pf_addr_r;
      word_r[tail_r] <= b_data;
    end else begin
      tag_r[tail_r]  <= tag_r[tail_r];
      word_r[tail_r] <= word_r[tail_r];
    end
  end

endmodule
